// File: rtl/ising_run_ctrl.sv
// Batch run controller for an oscillator Ising core: reset, anneal, capture, hand off.
// Optional ISING_STABLE_CHECK_EN adds a one-cycle CHECK state that re-samples phase after capture.
module ising_run_ctrl #(
    parameter int N        = 3,
    parameter int RST_HOLD = 4
) (
    input  logic          clk,
    input  logic          axi_rstn,
    input  logic          start,
    input  logic          abort,
    input  logic [15:0]   num_runs,
    input  logic [31:0]   run_cycles,
    output logic          ising_rstn,
    input  logic [N-1:0]  phase,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [N-1:0]  res_phase,
    output logic [15:0]   res_index,
    output logic          res_stable,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLD    = 3'd1,
        S_RUN     = 3'd2,
        S_CAPTURE = 3'd3,
`ifdef ISING_STABLE_CHECK_EN
        S_CHECK   = 3'd4,
`endif
        S_OUTPUT  = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t       state;
    state_t       next;
    logic         arm_q;
    logic         zero_q;
    logic [15:0]  runs_lat;
    logic [31:0]  cycles_lat;
    logic [7:0]   hold_cnt;
    logic [31:0]  run_cnt;
    logic         start_fire;
    logic         last_run;

    // start is taken into an arm flag first; the FSM leaves IDLE one edge later
    assign start_fire = (state == S_IDLE) && start && !arm_q;
    assign last_run   = (res_index == runs_lat - 16'd1);

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state <= S_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next       = state;
        ising_rstn = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (arm_q) begin
                    next = zero_q ? S_DONE : S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_cnt == 8'd1) begin
                    next = S_RUN;
                end
            end
            S_RUN: begin
                ising_rstn = 1'b1;
                if (run_cnt == 32'd1) begin
                    next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                ising_rstn = 1'b1;
`ifdef ISING_STABLE_CHECK_EN
                next = S_CHECK;
`else
                next = S_OUTPUT;
`endif
            end
`ifdef ISING_STABLE_CHECK_EN
            S_CHECK: begin
                ising_rstn = 1'b1;
                next       = S_OUTPUT;
            end
`endif
            S_OUTPUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    next = last_run ? S_DONE : S_HOLD;
                end
            end
            S_DONE: begin
                done = 1'b1;
                next = S_IDLE;
            end
            default: begin
                next = S_IDLE;
            end
        endcase
        if (abort && (state != S_IDLE)) begin
            next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            arm_q      <= 1'b0;
            zero_q     <= 1'b0;
            runs_lat   <= '0;
            cycles_lat <= '0;
        end else begin
            arm_q <= start_fire;
            if (start_fire) begin
                zero_q     <= (num_runs == 16'd0);
                runs_lat   <= num_runs;
                cycles_lat <= run_cycles;
            end
        end
    end

    // counters load on entry so every run restarts from the full count
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            hold_cnt <= '0;
            run_cnt  <= '0;
        end else begin
            if ((next == S_HOLD) && (state != S_HOLD)) begin
                hold_cnt <= 8'(RST_HOLD);
            end else if (state == S_HOLD) begin
                hold_cnt <= hold_cnt - 8'd1;
            end
            if ((next == S_RUN) && (state != S_RUN)) begin
                run_cnt <= (cycles_lat == 32'd0) ? 32'd1 : cycles_lat;
            end else if (state == S_RUN) begin
                run_cnt <= run_cnt - 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            res_phase  <= '0;
            res_index  <= '0;
            res_stable <= 1'b0;
        end else begin
            if (start_fire && (num_runs != 16'd0)) begin
                res_index <= '0;
            end else if ((state == S_OUTPUT) && (next == S_HOLD)) begin
                res_index <= res_index + 16'd1;
            end
            if ((state == S_CAPTURE) && (next != S_IDLE)) begin
                res_phase <= phase;
`ifdef ISING_STABLE_CHECK_EN
                res_stable <= 1'b0;
`else
                res_stable <= 1'b1;
`endif
            end
`ifdef ISING_STABLE_CHECK_EN
            if ((state == S_CHECK) && (next != S_IDLE)) begin
                res_stable <= (phase == res_phase);
            end
`endif
        end
    end

endmodule

// File: doc/ising_run_ctrl.md
ISING_RUN_CTRL -- requirements
Module: ising_run_ctrl

Interface
REQ-001 SHALL have parameter N, default 3: spin count, width of phase and res_phase.
REQ-002 SHALL have parameter RST_HOLD, default 4: cycles ising_rstn is held low before each run (legal range 1..255).
REQ-003 SHALL have ports, one per line:
 clk  input  1  single clock for all logic
 axi_rstn  input  1  asynchronous, active-low reset
 start  input  1  level, sampled in IDLE only; begins a batch
 abort  input  1  level, terminates the batch
 num_runs  input  16  runs per batch, latched at start
 run_cycles  input  32  anneal length in cycles, latched at start
 ising_rstn  output  1  reset driven to the oscillator core and sampler
 phase  input  N  sampler phase output
 res_valid  output  1  result available
 res_ready  input  1  consumer accepts result
 res_phase  output  N  captured spin vector
 res_index  output  16  run number of the current result, 0-based
 res_stable  output  1  phase unchanged across the stability check
 busy  output  1  high in every state except IDLE
 done  output  1  one-cycle pulse at batch completion

Function
REQ-004 SHALL implement states IDLE, HOLD, RUN, CAPTURE, CHECK (macro only), OUTPUT and DONE.
REQ-005 IDLE: ising_rstn=0, busy=0, res_valid=0; start=1 with num_runs!=0 SHALL latch num_runs and run_cycles, clear res_index, and enter HOLD.
REQ-006 IDLE: start=1 with num_runs==0 SHALL enter DONE directly; no run and no result.
REQ-007 start SHALL be ignored outside IDLE; holding it high SHALL NOT retrigger until IDLE is re-entered.
REQ-008 HOLD: ising_rstn=0 for exactly RST_HOLD cycles, then RUN.
REQ-009 RUN: ising_rstn=1 for exactly max(run_cycles,1) cycles; 32-bit counter with no wrap (run_cycles=0xFFFFFFFF runs that many cycles).
REQ-010 CAPTURE: one cycle, ising_rstn=1; res_phase SHALL load phase at the end of this cycle.
REQ-011 OUTPUT: ising_rstn=0; res_valid=1; res_phase, res_index and res_stable SHALL stay stable until res_valid&&res_ready.
REQ-012 On handshake with res_index==num_runs-1: go to DONE; otherwise increment res_index and go to HOLD.
REQ-013 DONE: done=1 for one cycle, busy=1, then IDLE; res_index keeps its last value.
REQ-014 Latency without the macro: first res_valid SHALL rise RST_HOLD+max(run_cycles,1)+2 cycles after the start-sampling edge.
REQ-015 abort=1 in any non-IDLE state SHALL move to IDLE on the next edge: res_valid=0, ising_rstn=0, no done pulse.
REQ-016 abort has priority over handshake and over count completion in the same cycle; abort in IDLE has no effect.
REQ-017 res_ready while res_valid=0 SHALL be ignored.

Reset
REQ-018 axi_rstn low SHALL asynchronously force IDLE, ising_rstn=0, res_valid=0, done=0, busy=0, res_phase=0, res_index=0, res_stable=0, counters=0.
REQ-019 Reset mid-batch SHALL discard the batch; after reset, the block waits for a new start.

Configuration
REQ-020 Macro ISING_STABLE_CHECK_EN: when defined, CAPTURE SHALL be followed by a one-cycle CHECK state (ising_rstn=1); res_stable=1 iff phase in CHECK equals res_phase. This adds one cycle to REQ-014.
REQ-021 When ISING_STABLE_CHECK_EN is not defined: the CHECK state does not exist, CAPTURE goes directly to OUTPUT, and res_stable SHALL read 1 whenever res_valid=1.

Verification
REQ-022 RST_HOLD=4, num_runs=1, run_cycles=10, phase=3'b101, res_ready=1 -> ising_rstn low 4 cycles, high 11 (12 with macro); res_valid rises 16 cycles after start; res_phase=101, index 0; done 1 cycle after handshake.
REQ-023 num_runs=3, res_ready held low 5 cycles per result -> three results, indices 0,1,2; outputs stable while stalled; ising_rstn=0 during stalls; single done pulse.
REQ-024 num_runs=0 -> no ising_rstn high, no res_valid, done pulse 2 cycles after start.
REQ-025 abort asserted in RUN at cycle 5 of 10, and separately in the same cycle as a final handshake -> IDLE next cycle, no done pulse, ising_rstn=0.
REQ-026 Macro defined, phase toggled between CAPTURE and CHECK -> res_stable=0; held constant -> res_stable=1; macro undefined -> res_stable=1.
REQ-027 axi_rstn pulsed low mid-OUTPUT -> all outputs at reset values immediately; a later start=1 runs a full batch correctly.
